// File: rtl/debounce_bank.sv
// Multi-channel synchroniser and debouncer: stable levels plus one-cycle
// press, release and long-press pulses per channel.
module debounce_bank #(
  parameter int unsigned         CHANNELS    = 4,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter int unsigned         COUNT_MAX   = 1_000_000,
  parameter int unsigned         HOLD_CYCLES = 100_000_000,
  parameter logic [CHANNELS-1:0] IDLE_LEVEL  = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] held
);

  localparam int unsigned CntW  = $clog2(COUNT_MAX + 1);
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(COUNT_MAX);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic                   cand_q, cand_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sample = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync_q <= {SYNC_STAGES{IDLE_LEVEL[c]}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], noisy[c]};
      end
    end

    // A sample change restarts the window; the counter saturates once stable.
    always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sample != cand_q) begin
        cand_d = sample;
        cnt_d  = '0;
      end else if (cnt_q == CntMax) begin
        clean_d = cand_q;
        rise_d  = cand_q & ~clean_q;
        fall_d  = ~cand_q & clean_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cand_q  <= IDLE_LEVEL[c];
        cnt_q   <= '0;
        clean_q <= IDLE_LEVEL[c];
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        cand_q  <= cand_d;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign clean[c] = clean_q;
    assign rise[c]  = rise_q;
    assign fall[c]  = fall_q;

    if (HOLD_CYCLES == 0) begin : g_no_hold
      assign held[c] = 1'b0;
    end else begin : g_hold
      localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

      logic [HoldW-1:0] hcnt_q, hcnt_d;
      logic             hold_done_q, hold_done_d;
      logic             held_q, held_d;

      // Fires once per press; releasing clean re-arms the counter.
      always_comb begin
        hcnt_d      = hcnt_q;
        hold_done_d = hold_done_q;
        held_d      = 1'b0;
        if (!clean_q) begin
          hcnt_d      = '0;
          hold_done_d = 1'b0;
        end else if (!hold_done_q) begin
          if (hcnt_q == HoldLast) begin
            held_d      = 1'b1;
            hold_done_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          hcnt_q      <= '0;
          hold_done_q <= 1'b0;
          held_q      <= 1'b0;
        end else begin
          hcnt_q      <= hcnt_d;
          hold_done_q <= hold_done_d;
          held_q      <= held_d;
        end
      end

      assign held[c] = held_q;
    end
  end

endmodule
